// File: rtl/obi_arb_pkg.sv
// ---------------------------------------------------------------------------
// obi_arb_pkg
// Shared types and constants for the two-port OBI memory arbiter.
//   src_id_t   : identifies the core port that issued a transaction
//   SRC_INSTR  : instruction port (port 0)
//   SRC_DATA   : data port (port 1)
//   obi_req_t  : request payload {addr, we, be, wdata}
//   obi_rsp_t  : response payload {rvalid, err, rdata}
// ---------------------------------------------------------------------------
package obi_arb_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_BE_W   = OBI_DATA_W / 8;

  typedef logic src_id_t;

  localparam src_id_t SRC_INSTR = 1'b0;
  localparam src_id_t SRC_DATA  = 1'b1;

  typedef struct packed {
    logic [OBI_ADDR_W-1:0] addr;
    logic                  we;
    logic [OBI_BE_W-1:0]   be;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  rvalid;
    logic                  err;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_rsp_t;

endpackage

// File: rtl/obi_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// obi_mem_arbiter_if
// Bundles the core-side ports (index 0 = instr, 1 = data), the unified
// memory port and the protocol error flag of the arbiter.
//   slave  : the arbiter's view (takes core requests, drives the memory)
//   master : the surrounding system (core ports + memory model)
// ---------------------------------------------------------------------------
interface obi_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // core side
  logic [1:0]             p_req_i;
  logic [1:0]             p_gnt_o;
  logic [1:0][ADDR_W-1:0] p_addr_i;
  logic [1:0]             p_we_i;
  logic [1:0][BE_W-1:0]   p_be_i;
  logic [1:0][DATA_W-1:0] p_wdata_i;
  logic [1:0]             p_rvalid_o;
  logic [1:0]             p_err_o;
  logic [1:0][DATA_W-1:0] p_rdata_o;

  // memory side
  logic                   mem_req_o;
  logic [ADDR_W-1:0]      mem_addr_o;
  logic                   mem_we_o;
  logic [BE_W-1:0]        mem_be_o;
  logic [DATA_W-1:0]      mem_wdata_o;
  logic                   mem_rvalid_i;
  logic                   mem_err_i;
  logic [DATA_W-1:0]      mem_rdata_i;

  logic                   proto_err_o;

  modport slave (
    input  p_req_i, p_addr_i, p_we_i, p_be_i, p_wdata_i,
    input  mem_rvalid_i, mem_err_i, mem_rdata_i,
    output p_gnt_o, p_rvalid_o, p_err_o, p_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output proto_err_o
  );

  modport master (
    output p_req_i, p_addr_i, p_we_i, p_be_i, p_wdata_i,
    output mem_rvalid_i, mem_err_i, mem_rdata_i,
    input  p_gnt_o, p_rvalid_o, p_err_o, p_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  proto_err_o
  );

endinterface

// File: rtl/obi_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// obi_arb_id_fifo
// Synchronous FIFO of source IDs, one entry per in-flight transaction.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, din     : enqueue the issuing port of a granted request
//   pop, dout     : dequeue on a memory response; dout is the head entry
//   empty, full   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
// The caller never pushes when full nor pops when empty.
// ---------------------------------------------------------------------------
module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  src_id_t          din,
  input  logic             pop,
  output src_id_t          dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  src_id_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is carried entirely by
  // the pointers and count, so clearing it would only cost reset routing.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

endmodule

// File: rtl/obi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// obi_mem_arbiter
// Merges the instruction (port 0) and data (port 1) OBI ports onto a single
// memory port with no grant and fixed-latency, in-order responses.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : obi_mem_arbiter_if.slave -- core ports, memory port, proto_err_o
// Round-robin between simultaneous requests; each grant records its source
// port in an ID FIFO so the matching in-order response is routed back.
// A response with nothing outstanding sets the sticky proto_err_o.
// ---------------------------------------------------------------------------
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  obi_mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             room;
  logic [1:0]       gnt;
  src_id_t          gnt_id;
  src_id_t          head_id;
  src_id_t          last_grant;
  logic             push;
  logic             pop;
  logic             proto_err;

  logic [ADDR_W-1:0]      sel_addr;
  logic                   sel_we;
  logic [BE_W-1:0]        sel_be;
  logic [DATA_W-1:0]      sel_wdata;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_err;
  logic [1:0][DATA_W-1:0] rsp_rdata;

  // Room depends only on the registered count: a response arriving this
  // cycle does not free a slot until the next cycle (no rvalid->gnt path).
  assign room = (count < MAX_CNT);

  // NOTE: every combinational output gets a default before any branch so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = '0;
    // Reset gates the grant directly so nothing is accepted while held.
    if (rst_ni && room) begin
      case (bus.p_req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == SRC_DATA) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  assign gnt_id = gnt[1];
  assign push   = |gnt;
  assign pop    = rst_ni && bus.mem_rvalid_i && !empty;

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    if (push) begin
      sel_addr  = bus.p_addr_i[gnt_id];
      sel_we    = bus.p_we_i[gnt_id];
      sel_be    = bus.p_be_i[gnt_id];
      sel_wdata = bus.p_wdata_i[gnt_id];
    end
  end

  // Response routing: only the port at the FIFO head sees the response.
  always_comb begin
    rsp_valid = '0;
    rsp_err   = '0;
    rsp_rdata = '0;
    if (pop) begin
      rsp_valid[head_id] = 1'b1;
      rsp_err[head_id]   = bus.mem_err_i;
      rsp_rdata[head_id] = bus.mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= SRC_DATA;
      proto_err  <= 1'b0;
    end else begin
      if (push) last_grant <= gnt_id;
      if (bus.mem_rvalid_i && empty) proto_err <= 1'b1;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .din    (gnt_id),
    .pop    (pop),
    .dout   (head_id),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

  assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !full);

  assign bus.p_gnt_o     = gnt;
  assign bus.mem_req_o   = push;
  assign bus.mem_addr_o  = sel_addr;
  assign bus.mem_we_o    = sel_we;
  assign bus.mem_be_o    = sel_be;
  assign bus.mem_wdata_o = sel_wdata;
  assign bus.p_rvalid_o  = rsp_valid;
  assign bus.p_err_o     = rsp_err;
  assign bus.p_rdata_o   = rsp_rdata;
  assign bus.proto_err_o = proto_err;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_obi_mem_arbiter
// Self-checking bench for obi_mem_arbiter. A fixed-latency memory model
// answers every accepted request; a transaction-level reference (a queue of
// issuing ports, the last winner and a sticky error bit) predicts every
// core-side and memory-side output once per cycle. Directed scenarios add
// literal expectations; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_obi_mem_arbiter;
  import obi_arb_pkg::*;

  localparam int MAX_OUT = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int BW      = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  obi_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  obi_mem_arbiter #(
    .MAX_OUTSTANDING (MAX_OUT),
    .ADDR_W          (AW),
    .DATA_W          (DW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  src_id_t m_ids[$];
  src_id_t m_last;
  bit      m_proto;

  task automatic model_reset();
    m_ids.delete();
    m_last  = SRC_DATA;
    m_proto = 1'b0;
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    int       due;
    obi_rsp_t rsp;
  } pend_t;

  pend_t           rsp_q[$];
  logic [DW-1:0]   ram [logic [AW-1:0]];
  int              lat      = 1;
  bit              echo     = 1'b1;
  bit              rand_err = 1'b0;
  bit              inject   = 1'b0;

  task automatic memory_accept();
    pend_t         p;
    logic [AW-1:0] a;
    logic [DW-1:0] word;
    a    = bus.mem_addr_o;
    word = ram.exists(a) ? ram[a] : '0;
    p.due        = cyc + lat;
    p.rsp.rvalid = 1'b1;
    p.rsp.err    = rand_err ? ($urandom_range(3) == 0) : 1'b0;
    p.rsp.rdata  = echo ? DW'(a) : word;
    if (bus.mem_we_o) begin
      for (int b = 0; b < BW; b++)
        if (bus.mem_be_o[b]) word[b*8 +: 8] = bus.mem_wdata_o[b*8 +: 8];
      ram[a] = word;
    end
    rsp_q.push_back(p);
  endtask

  task automatic drive_mem();
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_err_i    = rsp_q[0].rsp.err;
      bus.mem_rdata_i  = rsp_q[0].rsp.rdata;
      void'(rsp_q.pop_front());
    end else if (inject && rsp_q.size() == 0) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_err_i    = 1'b0;
      bus.mem_rdata_i  = $urandom;
      inject           = 1'b0;
    end else begin
      // noise on the data lines: nothing may leak to the core ports
      bus.mem_rvalid_i = 1'b0;
      bus.mem_err_i    = 1'($urandom);
      bus.mem_rdata_i  = $urandom;
    end
  endtask

  // ---------------- observation logs (from DUT outputs) ----------------
  int            gnt_log[$];
  int            gnt_cyc[$];
  int            rv_port_log[$];
  int            rv_cyc0[$];
  logic [DW-1:0] rd0[$];
  logic [DW-1:0] rd1[$];
  int            dut_out = 0;
  int            dut_out_max = 0;
  logic          last_we;
  logic [BW-1:0] last_be;
  bit            hold [2];

  task automatic clear_logs();
    gnt_log.delete(); gnt_cyc.delete(); rv_port_log.delete();
    rv_cyc0.delete(); rd0.delete(); rd1.delete();
    dut_out_max = dut_out;
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic we,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
    bus.p_req_i[p]   = 1'b1;
    bus.p_addr_i[p]  = a;
    bus.p_we_i[p]    = we;
    bus.p_be_i[p]    = be;
    bus.p_wdata_i[p] = wd;
  endtask

  task automatic clr_req(input int p);
    bus.p_req_i[p] = 1'b0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // drive the next cycle's inputs shortly after the rising edge.
  task automatic step();
    logic [1:0]             eg;
    logic [1:0]             erv;
    logic [1:0]             eerr;
    logic [1:0][DW-1:0]     erd;
    logic [1:0]             granted;
    src_id_t                gp;
    granted = '0;
    @(negedge clk);
    if (!rst_n) begin
      check("gnt_in_reset",    bus.p_gnt_o, 2'b00);
      check("rvalid_in_reset", bus.p_rvalid_o, 2'b00);
      check("mem_req_in_reset", bus.mem_req_o, 1'b0);
      check("proto_in_reset",  bus.proto_err_o, 1'b0);
    end else begin
      eg = 2'b00;
      if (m_ids.size() < MAX_OUT) begin
        if (bus.p_req_i == 2'b11) eg = (m_last == SRC_DATA) ? 2'b01 : 2'b10;
        else                      eg = bus.p_req_i;
      end
      check("p_gnt", bus.p_gnt_o, eg);
      check("mem_req", bus.mem_req_o, |eg);
      if (|eg) begin
        gp = eg[1];
        check("mem_addr",  bus.mem_addr_o,  bus.p_addr_i[gp]);
        check("mem_we",    bus.mem_we_o,    bus.p_we_i[gp]);
        check("mem_be",    bus.mem_be_o,    bus.p_be_i[gp]);
        check("mem_wdata", bus.mem_wdata_o, bus.p_wdata_i[gp]);
      end else begin
        check("mem_fields_idle",
              {bus.mem_addr_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o} == '0, 1'b1);
      end

      erv = '0; eerr = '0; erd = '0;
      if (bus.mem_rvalid_i && m_ids.size() > 0) begin
        erv[m_ids[0]]  = 1'b1;
        eerr[m_ids[0]] = bus.mem_err_i;
        erd[m_ids[0]]  = bus.mem_rdata_i;
      end
      check("p_rvalid", bus.p_rvalid_o, erv);
      check("p_err",    bus.p_err_o, eerr);
      check("p_rdata0", bus.p_rdata_o[0], erd[0]);
      check("p_rdata1", bus.p_rdata_o[1], erd[1]);
      check("proto_err", bus.proto_err_o, m_proto);

      // log what the DUT did
      granted = bus.p_gnt_o;
      if (|bus.p_gnt_o) begin
        gnt_log.push_back(int'(bus.p_gnt_o[1]));
        gnt_cyc.push_back(cyc);
        dut_out++;
        last_we = bus.mem_we_o;
        last_be = bus.mem_be_o;
      end
      for (int p = 0; p < 2; p++) begin
        if (bus.p_rvalid_o[p]) begin
          rv_port_log.push_back(p);
          dut_out--;
          if (p == 0) begin rd0.push_back(bus.p_rdata_o[0]); rv_cyc0.push_back(cyc); end
          else        rd1.push_back(bus.p_rdata_o[1]);
        end
      end
      if (dut_out > dut_out_max) dut_out_max = dut_out;

      // advance the model
      if (bus.mem_rvalid_i) begin
        if (m_ids.size() > 0) void'(m_ids.pop_front());
        else                  m_proto = 1'b1;
      end
      if (|eg) begin
        m_ids.push_back(eg[1]);
        m_last = eg[1];
      end

      if (bus.mem_req_o) memory_accept();
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int p = 0; p < 2; p++)
      if (granted[p] && !hold[p]) clr_req(p);
    drive_mem();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    dut_out = 0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((rsp_q.size() > 0 || bus.p_req_i != 2'b00) && k < budget) begin
      step();
      k++;
    end
    check("drain_in_budget", k < budget, 1'b1);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.p_req_i = '0; bus.p_addr_i = '0; bus.p_we_i = '0;
    bus.p_be_i = '0; bus.p_wdata_i = '0;
    bus.mem_rvalid_i = 1'b0; bus.mem_err_i = 1'b0; bus.mem_rdata_i = '0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    rst_n = 1'b0;
    #1;

    // Reset: requests held high must not be granted.
    set_req(0, 32'h100, 1'b0, 4'hF, '0);
    set_req(1, 32'h100, 1'b0, 4'hF, '0);
    do_reset(2);
    clr_req(0); clr_req(1);
    step();

    // A: port 0 alone, latency 1, memory echoes the address.
    lat = 1; echo = 1'b1; clear_logs();
    hold[0] = 1'b1;
    set_req(0, 32'h100, 1'b0, 4'hF, '0);
    repeat (10) step();
    hold[0] = 1'b0; clr_req(0);
    drain(10);
    check("A_grants",         gnt_log.size(), 10);
    check("A_grants_port0",   gnt_log.sum(), 0);
    check("A_rvalid0_count",  rd0.size(), 10);
    check("A_rvalid1_count",  rd1.size(), 0);
    check("A_rdata",          rd0[0], 32'h100);
    check("A_latency",        rv_cyc0[0] - gnt_cyc[0], 1);

    // B: both ports from reset -> alternate starting with port 0.
    do_reset(2);
    clear_logs();
    hold[0] = 1'b1; hold[1] = 1'b1;
    set_req(0, 32'h200, 1'b0, 4'hF, '0);
    set_req(1, 32'h8000, 1'b0, 4'hF, '0);
    repeat (8) step();
    hold[0] = 1'b0; hold[1] = 1'b0; clr_req(0); clr_req(1);
    drain(10);
    check("B_grant_order", {gnt_log[0][0], gnt_log[1][0], gnt_log[2][0], gnt_log[3][0]}, 4'b0101);
    check("B_rsp_order",   {rv_port_log[0][0], rv_port_log[1][0], rv_port_log[2][0], rv_port_log[3][0]}, 4'b0101);
    check("B_rdata1",      rd1[0], 32'h8000);
    check("B_rdata0",      rd0[0], 32'h200);

    // C: latency 8, port 1 continuous -> 4 grants then stall.
    lat = 8; clear_logs();
    hold[1] = 1'b1;
    set_req(1, 32'h300, 1'b0, 4'hF, '0);
    repeat (9) step();
    check("C_grants_before_rsp", gnt_log.size(), 4);
    repeat (30) step();
    check("C_max_outstanding", dut_out_max, 4);
    hold[1] = 1'b0; clr_req(1);
    drain(20);

    // D: partial write by port 1, then read back by port 0.
    lat = 2; echo = 1'b0; clear_logs();
    set_req(1, 32'h40, 1'b1, 4'b0011, 32'hAABBCCDD);
    step();
    check("D_mem_we", last_we, 1'b1);
    check("D_mem_be", last_be, 4'b0011);
    drain(10);
    check("D_write_rsp_port1", rd1.size(), 1);
    check("D_write_rsp_port0", rd0.size(), 0);
    set_req(0, 32'h40, 1'b0, 4'hF, '0);
    drain(10);
    check("D_readback", rd0[0], 32'h0000CCDD);

    // E: response with nothing outstanding.
    clear_logs();
    inject = 1'b1;
    repeat (3) step();
    check("E_no_rvalid", rv_port_log.size(), 0);
    repeat (5) step();
    check("E_proto_sticky", bus.proto_err_o, 1'b1);
    do_reset(1);
    check("E_proto_cleared", bus.proto_err_o, 1'b0);

    // F: asynchronous reset with 3 requests in flight.
    lat = 8; echo = 1'b1; clear_logs();
    hold[1] = 1'b1;
    set_req(1, 32'h500, 1'b0, 4'hF, '0);
    repeat (3) step();
    hold[1] = 1'b0;
    set_req(0, 32'h600, 1'b0, 4'hF, '0);
    #1;
    check("F_gnt_before_reset", bus.p_gnt_o, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("F_gnt_async_reset",    bus.p_gnt_o, 2'b00);
    check("F_rvalid_async_reset", bus.p_rvalid_o, 2'b00);
    model_reset();
    dut_out = 0;
    clr_req(0); clr_req(1);
    repeat (2) step();
    rst_n = 1'b1;
    drain(20);
    check("F_stale_rsp_proto", bus.proto_err_o, 1'b1);
    clear_logs();
    set_req(0, 32'h700, 1'b0, 4'hF, '0);
    set_req(1, 32'h704, 1'b0, 4'hF, '0);
    step();
    check("F_first_grant_port0", gnt_log.size() == 1 && gnt_log[0] == 0, 1'b1);
    drain(30);
    do_reset(1);

    // G: randomized traffic over a small address window.
    echo = 1'b0; rand_err = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      lat = $urandom_range(5, 1);
      for (int n = 0; n < 300; n++) begin
        for (int p = 0; p < 2; p++)
          if (!bus.p_req_i[p] && $urandom_range(1) == 1)
            set_req(p, AW'($urandom_range(15) * 4), 1'($urandom), BW'($urandom), $urandom);
        step();
      end
      clr_req(0); clr_req(1);
      drain(20);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Merges the core's two memory request ports, instruction (port 0) and data (port 1), onto the single unified memory port of the SoC memory.
- Arbitration is round-robin with grant/rvalid handshakes on the core side.
- The memory side has no grant. It accepts one request per cycle and returns exactly one in-order response per request after a fixed latency.
- Tracks outstanding transactions in a source-ID FIFO so each response is routed back to the port that issued it.

Parameters:
- MAX_OUTSTANDING, 4: maximum in-flight requests; depth of the ID FIFO. Must be >= 1.
- ADDR_W, 32: address width.
- DATA_W, 32: data width. be width is DATA_W/8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- p_req_i[2]  in  1 each  request from port 0 (instr) / port 1 (data)
- p_gnt_o[2]  out  1 each  request accepted this cycle
- p_addr_i[2]  in  ADDR_W each  address
- p_we_i[2]  in  1 each  write enable
- p_be_i[2]  in  DATA_W/8 each  byte enables
- p_wdata_i[2]  in  DATA_W each  write data
- p_rvalid_o[2]  out  1 each  response valid
- p_err_o[2]  out  1 each  response error
- p_rdata_o[2]  out  DATA_W each  read data
- mem_req_o  out  1  request to memory
- mem_addr_o  out  ADDR_W  address to memory
- mem_we_o  out  1  write enable to memory
- mem_be_o  out  DATA_W/8  byte enables to memory
- mem_wdata_o  out  DATA_W  write data to memory
- mem_rvalid_i  in  1  memory response valid
- mem_err_i  in  1  memory response error
- mem_rdata_i  in  DATA_W  memory read data
- proto_err_o  out  1  sticky: response arrived with no outstanding request

Behaviour:
- Single clock clk_i. rst_ni is asynchronous, active-low.
- Reset values:
  - outstanding count = 0, ID FIFO empty, proto_err_o = 0.
  - last_grant = 1, so port 0 wins the first conflict.
  - All p_gnt_o, p_rvalid_o and mem_req_o are 0 while in reset.
- room = (registered count < MAX_OUTSTANDING). room is computed from registered state only; there is no combinational rvalid->gnt path.
- Grant (combinational, zero latency):
  - If room and exactly one p_req_i is high, grant that port.
  - If room and both are high, grant the port != last_grant.
  - No room: no grant; requests stall and request fields must stay stable.
- mem_req_o = |p_gnt_o. mem_addr/we/be/wdata are muxed from the granted port; they are 0 when there is no grant.
- On grant: push the source ID (0/1) into the FIFO, count++, and update last_grant to the granted port.
- Writes also receive a response (memory answers every request).
- On mem_rvalid_i with FIFO non-empty:
  - Pop the FIFO, count--.
  - Drive p_rvalid_o[id] = 1, p_err_o[id] = mem_err_i, p_rdata_o[id] = mem_rdata_i, all combinationally in the same cycle.
  - The other port's rvalid stays 0.
- Push and pop in the same cycle: count unchanged, FIFO stays consistent. This holds at full as well: the grant was already blocked by room=0 there, so the case only arises below full.
- mem_rvalid_i with an empty FIFO: no p_rvalid_o is asserted, proto_err_o is set to 1 and held until reset. The FIFO is not modified.
- Responses are strictly in issue order. Response latency equals memory latency; the arbiter adds 0 cycles.
- p_err_o and p_rdata_o are 0 when the corresponding p_rvalid_o is 0.
- Reset mid-operation clears all in-flight state. Responses to pre-reset requests that arrive after reset release are treated as unexpected (proto_err_o).
- Count width is $clog2(MAX_OUTSTANDING+1). FIFO pointers wrap modulo MAX_OUTSTANDING.

Decomposition:
- Package obi_arb_pkg:
  - typedef src_id_t (1 bit).
  - Constants SRC_INSTR = 0 and SRC_DATA = 1.
  - Packed struct obi_req_t {addr, we, be, wdata} and struct obi_rsp_t {rvalid, err, rdata}, both parameterised through localparams matching the defaults.
- Sub-module obi_arb_id_fifo: synchronous FIFO of src_id_t, depth MAX_OUTSTANDING, with push/pop/empty/full/count. It uses the same asynchronous active-low reset.

Test Plan:
- Only port 0 requests addr 0x100 continuously, memory latency 1, mem_rdata = addr -> p_gnt_o[0] high every cycle; p_rvalid_o[0] one cycle after each grant with rdata 0x100; port 1 sees no rvalid.
- Both ports request from reset (p0 0x200, p1 0x8000, held) -> grants alternate 0,1,0,1; responses return in the same order, with p_rvalid_o toggling between the ports.
- Memory latency 8, MAX_OUTSTANDING = 4, port 1 requests continuously -> exactly 4 grants, then gnt stays 0 until the first rvalid; steady state never exceeds count 4.
- Port 1 writes be=4'b0011 with wdata 0xAABBCCDD to 0x40 -> mem_we_o=1, mem_be_o=0011; write response rvalid arrives on port 1; a following read by port 0 of 0x40 returns 0x0000CCDD with a zero-initialised memory.
- Inject mem_rvalid_i with nothing outstanding -> no p_rvalid_o; proto_err_o rises the next cycle and stays 1 until rst_ni is low.
- Drop rst_ni asynchronously with 3 requests in flight -> all p_gnt_o/p_rvalid_o go 0 immediately; after release the count is 0 and the first grant goes to port 0.
